instruction_decode_pipe: RTL and testbench
==========================================

// Module: instruction_decode_pipe
// PURPOSE
//  Parametrised ID stage for the MIPS pipeline, between IF and EX. Holds the
//  register file with optional WB->ID bypass and r0 hardwired to zero. Decodes
//  instructions into EX/MEM/WB control and resolves jumps and branches in ID.
//  Adds valid/ready handshakes on both sides, a flush input and a sticky
//  end-of-program state.
// PARAMETERS
//  DATA_WIDTH  32  register/PC/immediate width (>=32); arithmetic mod 2^DATA_WIDTH
//  WB_BYPASS   1   1: a same-cycle WB write is forwarded to the ID read ports
//  END_INSTR   32'hFFFFFFFF  instruction word that terminates the program
// PORTS
//  i_clk           in   1    clock, all state on posedge
//  i_reset         in   1    synchronous, active-high reset
//  i_instruction   in   32   instruction from IF
//  i_pc            in   DW   PC+4 of i_instruction
//  i_valid         in   1    IF presents a valid instruction
//  o_ready         out  1    ID accepts this cycle (combinational)
//  i_stall         in   1    hazard unit: insert bubble, hold IF
//  i_halt          in   1    debug halt: freeze stage, enable debug read
//  i_flush         in   1    discard the current input instruction
//  i_wb_we         in   1    WB register write enable
//  i_wb_addr       in   5    WB destination register
//  i_wb_data       in   DW   WB write data
//  o_valid         out  1    ID/EX register holds a real instruction
//  i_ready         in   1    EX accepts the ID/EX contents
//  o_RA            out  DW   rs data (PC for JAL/JALR)
//  o_RB            out  DW   rt data (4 for JAL/JALR)
//  o_imm           out  DW   sign-extended instr[15:0]
//  o_fields        out  32   {opcode,rs,rt,rd,shamt,funct}, rt/rd rewritten
//  o_ctl           out  11   {mem_to_reg,reg_write, rd,wr,uns,width[1:0], reg_dest,alu_op[1:0],alu_src}
//  o_jump          out  1    redirect IF (combinational)
//  o_jump_address  out  DW   jump/branch target (combinational)
//  o_reg_in_jump   out  2    00 none, 01 uses rs+rt, 10 uses rs only
//  i_reg_read      in   5    debug register index, used while i_halt
//  o_reg_content   out  DW   read-port-1 data (debug)
//  o_program_end   out  1    sticky: END_INSTR has been accepted
// BEHAVIOUR
//  Reset: all outputs and registers 0, all 32 regs 0, state RUN.
//  Regfile: write on posedge if i_wb_we and addr!=0. Reads are asynchronous.
//  Reads of r0 return 0. With WB_BYPASS, a read of addr==i_wb_addr!=0 while
//  i_wb_we returns i_wb_data. Port 1 index = i_halt ? i_reg_read : rs.
//  Writes continue during halt.
//  load = !i_halt & (!o_valid | i_ready).
//  o_ready = load & (i_flush | !i_stall). accept = i_valid & o_ready.
//  On load, a bubble is written (o_valid<=0, o_ctl<=0, other outputs hold) if
//  any of: flush | stall | !i_valid | NOP | END_INSTR | state DONE.
//  Otherwise the decode result is captured and o_valid<=1. Latency is 1 cycle.
//  !load: every output holds. Flush beats stall. A flushed END_INSTR is ignored.
//  FSM: RUN->DONE on accept of END_INSTR with !i_flush. DONE exits only by reset.
//  In DONE, o_ready stays as above and inputs are consumed as bubbles.
//  o_program_end = (state==DONE); it rises the cycle after END_INSTR is accepted.
//  Control encoding:
//   R-type: wb=11 (JR: 10), reg_dest=1, alu_src=0, alu_op=10 (JALR: 00).
//   Load (op[5:3]=100): wb=01.
//   Imm (op[5:3]=001): wb=11, alu_op=11.
//   JAL: wb=11, alu_op=00.
//   Store/branch: wb=10.
//   Non-R: reg_dest=0, alu_src=1; ld/st alu_op=00, branch alu_op=01.
//   Ld/st (op[5]): uns=op[2], width=op[1:0], wr=op[3], rd=!op[3].
//  JAL/JALR: o_RA=i_pc, o_RB=4, rt field=0; JAL rd=31.
//  Jumps: o_jump only when i_valid & !i_stall & !i_halt & !i_flush & RUN.
//   BEQ/BNE: target i_pc+(imm<<2), taken on equal / not-equal bypassed data.
//   J/JAL: {i_pc[DW-1:28], instr[25:0], 2'b00}. JR/JALR: target rs data, reg_in_jump 10.
//   Otherwise o_jump=0, o_jump_address=0, o_reg_in_jump=00.
// TESTING
//  WB writes r5=0x1234 while ADD r3,r5,r0 (0x00A01820) is valid -> next cycle o_RA=0x1234, o_ctl[10:9]=11, o_valid=1.
//  r1=r2=7, BEQ r1,r2,+3 (0x10220003), i_pc=0x100 -> same cycle o_jump=1, addr 0x10C, reg_in_jump=01.
//  o_valid=1, i_ready=0 for 3 cycles -> outputs hold, o_ready=0; i_ready=1 -> next instruction captured next cycle.
//  JAL 0x0C000010, i_pc=0x8 -> o_jump=1, addr 0x40; next cycle o_RA=8, o_RB=4, rd=31, o_ctl[10:9]=11.
//  Accept 0xFFFFFFFF -> o_program_end=1 next cycle, o_valid stays 0 for later inputs; i_reset clears both.
//  i_halt=1, i_reg_read=5 -> o_reg_content=0x1234, outputs frozen, o_ready=0; WB write r0=9 -> r0 reads 0.

Source files
------------

// File: rtl/instruction_decode_pipe_if.sv
// Bus between IF, hazard unit, WB, EX and the ID stage.
// master = surrounding pipeline, slave = ID stage.
interface instruction_decode_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [31:0]           instruction;
    logic [DATA_WIDTH-1:0] pc;
    logic                  if_valid;
    logic                  id_ready;
    logic                  stall;
    logic                  halt;
    logic                  flush;
    logic                  wb_we;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [DATA_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rb;
    logic [DATA_WIDTH-1:0] imm;
    logic [31:0]           fields;
    logic [10:0]           ctl;
    logic                  jump;
    logic [DATA_WIDTH-1:0] jump_address;
    logic [1:0]            reg_in_jump;
    logic [4:0]            reg_read;
    logic [DATA_WIDTH-1:0] reg_content;
    logic                  program_end;

    modport master (
        output instruction, pc, if_valid, stall, halt, flush, wb_we, wb_addr, wb_data,
               ex_ready, reg_read,
        input  id_ready, ex_valid, ra, rb, imm, fields, ctl, jump, jump_address,
               reg_in_jump, reg_content, program_end
    );

    modport slave (
        input  instruction, pc, if_valid, stall, halt, flush, wb_we, wb_addr, wb_data,
               ex_ready, reg_read,
        output id_ready, ex_valid, ra, rb, imm, fields, ctl, jump, jump_address,
               reg_in_jump, reg_content, program_end
    );
endinterface

// File: rtl/instruction_decode_pipe.sv
// MIPS ID stage: register file, control decode, jump/branch resolution in ID,
// valid/ready handshakes on both sides, flush and a sticky end-of-program state.
module instruction_decode_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          WB_BYPASS  = 1'b1,
    parameter logic [31:0] END_INSTR  = 32'hFFFF_FFFF
) (
    input logic                      i_clk,
    input logic                      i_reset,
    instruction_decode_pipe_if.slave bus
);
    typedef enum logic {StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] regs_q [32];

    logic [5:0]            op, funct;
    logic [4:0]            rs, rt, rd, shamt, rd1_idx;
    logic [DATA_WIDTH-1:0] rd1, rd2, imm_ext;

    logic is_r, is_jr, is_jalr, is_j, is_jal, is_br, is_ld, is_imm, is_link;
    logic load, accept, bubble, is_end;

    logic [1:0]  wb, width, alu_op;
    logic        mem_rd, mem_wr, uns, reg_dest, alu_src;
    logic [10:0] ctl_d;

    logic                  valid_q;
    logic [10:0]           ctl_q;
    logic [DATA_WIDTH-1:0] ra_q, rb_q, imm_q;
    logic [31:0]           fields_q;

    assign op      = bus.instruction[31:26];
    assign rs      = bus.instruction[25:21];
    assign rt      = bus.instruction[20:16];
    assign rd      = bus.instruction[15:11];
    assign shamt   = bus.instruction[10:6];
    assign funct   = bus.instruction[5:0];
    assign imm_ext = {{(DATA_WIDTH-16){bus.instruction[15]}}, bus.instruction[15:0]};
    assign rd1_idx = bus.halt ? bus.reg_read : rs;

    // Register file; writes keep going while halted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rd1 = regs_q[rd1_idx];
        if (WB_BYPASS && bus.wb_we && bus.wb_addr == rd1_idx) rd1 = bus.wb_data;
        if (rd1_idx == 5'd0) rd1 = '0;
        rd2 = regs_q[rt];
        if (WB_BYPASS && bus.wb_we && bus.wb_addr == rt) rd2 = bus.wb_data;
        if (rt == 5'd0) rd2 = '0;
    end

    assign bus.reg_content = rd1;

    assign is_r    = op == 6'h00;
    assign is_jr   = is_r && funct == 6'h08;
    assign is_jalr = is_r && funct == 6'h09;
    assign is_j    = op == 6'h02;
    assign is_jal  = op == 6'h03;
    assign is_br   = op[5:1] == 5'b00010;
    assign is_ld   = op[5:3] == 3'b100;
    assign is_imm  = op[5:3] == 3'b001;
    assign is_link = is_jal || is_jalr;

    always_comb begin
        wb       = 2'b10;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        uns      = 1'b0;
        width    = 2'b00;
        reg_dest = 1'b0;
        alu_op   = 2'b00;
        alu_src  = 1'b1;
        if (is_r) begin
            wb       = is_jr ? 2'b10 : 2'b11;
            reg_dest = 1'b1;
            alu_src  = 1'b0;
            alu_op   = is_jalr ? 2'b00 : 2'b10;
        end else begin
            if (is_ld) begin
                wb = 2'b01;
            end else if (is_imm) begin
                wb     = 2'b11;
                alu_op = 2'b11;
            end else if (is_jal) begin
                wb = 2'b11;
            end
            if (is_br) alu_op = 2'b01;
            if (op[5]) begin
                mem_rd = !op[3];
                mem_wr = op[3];
                uns    = op[2];
                width  = op[1:0];
            end
        end
        ctl_d = {wb, mem_rd, mem_wr, uns, width, reg_dest, alu_op, alu_src};
    end

    // Branches present their target whenever decoded; o_jump reflects the outcome.
    always_comb begin
        bus.jump         = 1'b0;
        bus.jump_address = '0;
        bus.reg_in_jump  = 2'b00;
        if (bus.if_valid && !bus.stall && !bus.halt && !bus.flush && state_q == StRun) begin
            if (is_br) begin
                bus.jump_address = bus.pc + (imm_ext << 2);
                bus.reg_in_jump  = 2'b01;
                bus.jump         = op[0] ? (rd1 != rd2) : (rd1 == rd2);
            end else if (is_j || is_jal) begin
                bus.jump         = 1'b1;
                bus.jump_address = {bus.pc[DATA_WIDTH-1:28], bus.instruction[25:0], 2'b00};
            end else if (is_jr || is_jalr) begin
                bus.jump         = 1'b1;
                bus.jump_address = rd1;
                bus.reg_in_jump  = 2'b10;
            end
        end
    end

    assign is_end       = bus.instruction == END_INSTR;
    assign load         = !bus.halt && (!valid_q || bus.ex_ready);
    assign bus.id_ready = load && (bus.flush || !bus.stall);
    assign accept       = bus.if_valid && bus.id_ready;
    assign bubble       = bus.flush || bus.stall || !bus.if_valid || bus.instruction == 32'd0 ||
                          is_end || state_q == StDone;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= StRun;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == StRun && accept && is_end && !bus.flush) state_d = StDone;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q  <= 1'b0;
            ctl_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            fields_q <= '0;
        end else if (load) begin
            if (bubble) begin
                valid_q <= 1'b0;
                ctl_q   <= '0;
            end else begin
                valid_q  <= 1'b1;
                ctl_q    <= ctl_d;
                ra_q     <= is_link ? bus.pc : rd1;
                rb_q     <= is_link ? DATA_WIDTH'(4) : rd2;
                imm_q    <= imm_ext;
                fields_q <= {op, rs, is_link ? 5'd0 : rt, is_jal ? 5'd31 : rd, shamt, funct};
            end
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ctl         = ctl_q;
    assign bus.ra          = ra_q;
    assign bus.rb          = rb_q;
    assign bus.imm         = imm_q;
    assign bus.fields      = fields_q;
    assign bus.program_end = state_q == StDone;
endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Bench for instruction_decode_pipe: directed vectors with literal expectations plus
// an instruction-class model checked on every falling clock edge.
module tb_instruction_decode_pipe;
    localparam int unsigned DW    = 32;
    localparam logic [31:0] END_W = 32'hFFFF_FFFF;

    typedef enum {CR, CJR, CJALR, CLD, CST, CIMM, CBR, CJ, CJAL, COTH} cls_e;

    logic clk = 1'b0;
    logic reset;

    instruction_decode_pipe_if #(.DATA_WIDTH(DW)) bus ();

    instruction_decode_pipe #(
        .DATA_WIDTH(DW),
        .WB_BYPASS (1'b1),
        .END_INSTR (END_W)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the ID/EX register and regfile must hold
    logic [31:0] m_regs [32];
    logic        m_valid  = 1'b0;
    logic        m_done   = 1'b0;
    logic [10:0] m_ctl    = '0;
    logic [31:0] m_ra     = '0;
    logic [31:0] m_rb     = '0;
    logic [31:0] m_imm    = '0;
    logic [31:0] m_fields = '0;

    function automatic cls_e classify(input logic [31:0] w);
        if (w[31:26] == 6'd0) begin
            if (w[5:0] == 6'h08) return CJR;
            if (w[5:0] == 6'h09) return CJALR;
            return CR;
        end
        if (w[31:26] == 6'd2) return CJ;
        if (w[31:26] == 6'd3) return CJAL;
        if (w[31:26] == 6'd4 || w[31:26] == 6'd5) return CBR;
        if (w[31:29] == 3'b100) return CLD;
        if (w[31:29] == 3'b101) return CST;
        if (w[31:29] == 3'b001) return CIMM;
        return COTH;
    endfunction

    function automatic logic [10:0] mctl(input cls_e c, input logic [5:0] op);
        logic [1:0] wb = 2'b10;
        logic [1:0] aop = 2'b00;
        logic rdst = 1'b0, asrc = 1'b1, mr = 1'b0, mw = 1'b0;
        case (c)
            CR:    begin wb = 2'b11; rdst = 1'b1; asrc = 1'b0; aop = 2'b10; end
            CJR:   begin wb = 2'b10; rdst = 1'b1; asrc = 1'b0; aop = 2'b10; end
            CJALR: begin wb = 2'b11; rdst = 1'b1; asrc = 1'b0; aop = 2'b00; end
            CLD:   begin wb = 2'b01; mr = 1'b1; end
            CST:   begin wb = 2'b10; mw = 1'b1; end
            CIMM:  begin wb = 2'b11; aop = 2'b11; end
            CBR:   aop = 2'b01;
            CJAL:  wb = 2'b11;
            default: ;
        endcase
        if (c == CLD || c == CST) return {wb, mr, mw, op[2], op[1:0], rdst, aop, asrc};
        return {wb, 4'b0000, 1'b0, rdst, aop, asrc};
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_we && bus.wb_addr == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    logic [31:0] w, r1, r2, sx, e_addr;
    logic [1:0]  e_ric;
    logic        e_jump, e_load, e_ready, e_link;
    cls_e        c;

    initial begin
        forever begin
            @(negedge clk);
            w  = bus.instruction;
            c  = classify(w);
            sx = {{16{w[15]}}, w[15:0]};
            r1 = mread(bus.halt ? bus.reg_read : w[25:21]);
            r2 = mread(w[20:16]);
            e_load  = !bus.halt && (!m_valid || bus.ex_ready);
            e_ready = e_load && (bus.flush || !bus.stall);
            e_jump = 1'b0;
            e_addr = 32'd0;
            e_ric  = 2'b00;
            if (bus.if_valid && !bus.stall && !bus.halt && !bus.flush && !m_done) begin
                case (c)
                    CBR: begin
                        e_ric  = 2'b01;
                        e_addr = bus.pc + 32'd4 * sx;
                        e_jump = w[26] ? (r1 != r2) : (r1 == r2);
                    end
                    CJ, CJAL: begin
                        e_jump = 1'b1;
                        e_addr = {bus.pc[31:28], w[25:0], 2'b00};
                    end
                    CJR, CJALR: begin
                        e_jump = 1'b1;
                        e_addr = r1;
                        e_ric  = 2'b10;
                    end
                    default: ;
                endcase
            end
            chk("m_valid", bus.ex_valid, m_valid);
            chk("m_ctl", bus.ctl, m_ctl);
            chk("m_ra", bus.ra, m_ra);
            chk("m_rb", bus.rb, m_rb);
            chk("m_imm", bus.imm, m_imm);
            chk("m_fields", bus.fields, m_fields);
            chk("m_end", bus.program_end, m_done);
            chk("m_ready", bus.id_ready, e_ready);
            chk("m_jump", bus.jump, e_jump);
            chk("m_jaddr", bus.jump_address, e_addr);
            chk("m_ric", bus.reg_in_jump, e_ric);
            chk("m_regc", bus.reg_content, r1);

            if (reset) begin
                m_valid = 1'b0; m_ctl = '0; m_ra = '0; m_rb = '0; m_imm = '0; m_fields = '0;
                m_done  = 1'b0;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            end else begin
                if (e_load) begin
                    if (bus.flush || bus.stall || !bus.if_valid || w == 32'd0 || w == END_W ||
                        m_done) begin
                        m_valid = 1'b0;
                        m_ctl   = '0;
                    end else begin
                        e_link   = (c == CJAL) || (c == CJALR);
                        m_valid  = 1'b1;
                        m_ctl    = mctl(c, w[31:26]);
                        m_ra     = e_link ? bus.pc : r1;
                        m_rb     = e_link ? 32'd4 : r2;
                        m_imm    = sx;
                        m_fields = w;
                        if (e_link) m_fields[20:16] = 5'd0;
                        if (c == CJAL) m_fields[15:11] = 5'd31;
                    end
                end
                if (bus.if_valid && e_ready && w == END_W && !bus.flush) m_done = 1'b1;
                if (bus.wb_we && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
            end
        end
    end

    task automatic idle();
        bus.instruction = 32'd0; bus.pc = 32'd0; bus.if_valid = 1'b0;
        bus.stall = 1'b0; bus.halt = 1'b0; bus.flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        bus.ex_ready = 1'b1; bus.reg_read = 5'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] iw, input logic [31:0] pc);
        idle();
        bus.instruction = iw;
        bus.pc          = pc;
        bus.if_valid    = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc(); cyc();
        chk("rst_valid", bus.ex_valid, 1'b0);
        chk("rst_end", bus.program_end, 1'b0);
        chk("rst_ctl", bus.ctl, 11'h000);
        reset = 1'b0;

        idle(); wr(5'd1, 32'd7); cyc();
        idle(); wr(5'd2, 32'd7); cyc();

        // ADD r3,r5,r0 while WB writes r5 in the same cycle
        put(32'h00A01820, 32'h4); wr(5'd5, 32'h1234); cyc();
        chk("add_ra", bus.ra, 32'h1234);
        chk("add_wb", bus.ctl[10:9], 2'b11);
        chk("add_valid", bus.ex_valid, 1'b1);

        put(32'h10220003, 32'h100); #1;
        chk("beq_jump", bus.jump, 1'b1);
        chk("beq_addr", bus.jump_address, 32'h10C);
        chk("beq_ric", bus.reg_in_jump, 2'b01);
        cyc();

        put(32'h20040005, 32'h104); bus.ex_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_ready", bus.id_ready, 1'b0);
            chk("bp_ctl", bus.ctl, 11'h403);
            cyc();
        end
        bus.ex_ready = 1'b1; cyc();
        chk("addi_ctl", bus.ctl, 11'h607);
        chk("addi_imm", bus.imm, 32'h5);

        put(32'h8CA60008, 32'h108); cyc();
        chk("lw_ctl", bus.ctl, 11'h331);
        chk("lw_ra", bus.ra, 32'h1234);
        put(32'hACA60004, 32'h10C); cyc();
        chk("sw_ctl", bus.ctl, 11'h4B1);

        put(32'h1000FFFF, 32'h200); #1;
        chk("bneg_jump", bus.jump, 1'b1);
        chk("bneg_addr", bus.jump_address, 32'h1FC);
        cyc();
        put(32'h14220002, 32'h204); #1;
        chk("bne_nt", bus.jump, 1'b0);
        cyc();

        put(32'h0C000010, 32'h8); #1;
        chk("jal_jump", bus.jump, 1'b1);
        chk("jal_addr", bus.jump_address, 32'h40);
        cyc();
        chk("jal_ra", bus.ra, 32'h8);
        chk("jal_rb", bus.rb, 32'h4);
        chk("jal_rd", bus.fields[15:11], 5'd31);
        chk("jal_wb", bus.ctl[10:9], 2'b11);

        put(32'h00A0F809, 32'h20); #1;
        chk("jalr_addr", bus.jump_address, 32'h1234);
        chk("jalr_ric", bus.reg_in_jump, 2'b10);
        cyc();
        chk("jalr_ctl", bus.ctl, 11'h608);
        chk("jalr_ra", bus.ra, 32'h20);

        put(32'h00A00008, 32'h30); #1;
        chk("jr_addr", bus.jump_address, 32'h1234);
        cyc();
        chk("jr_ctl", bus.ctl, 11'h40C);

        put(32'h10220003, 32'h40); bus.stall = 1'b1; #1;
        chk("stall_ready", bus.id_ready, 1'b0);
        chk("stall_jump", bus.jump, 1'b0);
        cyc();
        chk("stall_bubble", bus.ex_valid, 1'b0);

        put(32'h00A01820, 32'h44); bus.stall = 1'b1; bus.flush = 1'b1; #1;
        chk("flush_ready", bus.id_ready, 1'b1);
        cyc();
        chk("flush_bubble", bus.ex_valid, 1'b0);

        put(END_W, 32'h48); bus.flush = 1'b1; cyc(); cyc();
        chk("flush_end", bus.program_end, 1'b0);

        put(32'h00A01820, 32'h50); cyc();

        // Halt: frozen outputs, debug read, writes still land
        put(32'h10220003, 32'h54); bus.halt = 1'b1; bus.reg_read = 5'd5; #1;
        chk("halt_regc", bus.reg_content, 32'h1234);
        chk("halt_ready", bus.id_ready, 1'b0);
        chk("halt_jump", bus.jump, 1'b0);
        wr(5'd0, 32'h9); cyc();
        chk("halt_ra", bus.ra, 32'h1234);
        chk("halt_valid", bus.ex_valid, 1'b1);
        bus.reg_read = 5'd0; #1;
        chk("halt_r0", bus.reg_content, 32'h0);
        bus.reg_read = 5'd7; wr(5'd7, 32'h55); #1;
        chk("halt_byp", bus.reg_content, 32'h55);
        cyc(); bus.wb_we = 1'b0; #1;
        chk("halt_wr", bus.reg_content, 32'h55);

        put(END_W, 32'h60); cyc();
        chk("end_rise", bus.program_end, 1'b1);
        chk("end_valid", bus.ex_valid, 1'b0);
        put(32'h00A01820, 32'h64); #1;
        chk("done_ready", bus.id_ready, 1'b1);
        cyc();
        chk("done_bubble", bus.ex_valid, 1'b0);
        put(32'h10220003, 32'h68); #1;
        chk("done_jump", bus.jump, 1'b0);
        cyc();

        reset = 1'b1; idle(); cyc();
        chk("rst2_end", bus.program_end, 1'b0);
        chk("rst2_valid", bus.ex_valid, 1'b0);
        reset = 1'b0;
        put(32'h00A01820, 32'h70); cyc();
        chk("post_valid", bus.ex_valid, 1'b1);
        chk("post_ra", bus.ra, 32'h0);
        idle(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
